// File: rtl/acumulador_ctrl.sv
// Run-length accumulator sequencer: sums `len` signed operands taken over a
// valid/ready handshake and publishes the result with Z/N/P and sticky overflow.
module acumulador_ctrl #(
  parameter int NUM_BITS = 8,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_BITS-1:0] len,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] S,
  output logic                Z,
  output logic                N,
  output logic                P,
  output logic                V
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_BITS-1:0] r_acc;
  logic [CNT_BITS-1:0] r_rem;
  logic                r_ovf;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic [NUM_BITS-1:0] r_s;
  logic                r_v;

  logic [NUM_BITS-1:0] w_sum;
  logic                w_accept;
  logic                w_ovf_next;

  // Signed overflow: operands share a sign that the wrapped sum does not.
  function automatic logic add_ovf(input logic [NUM_BITS-1:0] a,
                                   input logic [NUM_BITS-1:0] b,
                                   input logic [NUM_BITS-1:0] s);
    return (a[NUM_BITS-1] == b[NUM_BITS-1]) && (s[NUM_BITS-1] != a[NUM_BITS-1]);
  endfunction

  assign w_sum      = r_acc + in_data;
  assign w_accept   = in_valid & r_in_ready;
  assign w_ovf_next = r_ovf | add_ovf(r_acc, in_data, w_sum);

  // Sequencer state, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_rem      <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_s        <= '0;
      r_v        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc  <= '0;
            r_rem  <= len;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            if (len == '0) begin
              // Empty run: publish a zero result straight away.
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_s        <= '0;
              r_v        <= 1'b0;
            end else begin
              r_state    <= ST_ACC;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_ovf <= w_ovf_next;
            r_rem <= r_rem - CNT_BITS'(1);
            if (r_rem == CNT_BITS'(1)) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_s        <= w_sum;
              r_v        <= w_ovf_next;
            end else begin
              r_state <= ST_ACC;
            end
          end else begin
            r_state <= ST_ACC;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign S        = r_s;
  assign V        = r_v;
  assign Z        = (r_s == '0);
  assign N        = r_s[NUM_BITS-1];
  assign P        = ~r_s[0];

endmodule

// File: tb/tb_acumulador_ctrl.sv
// Scenario-driven bench for acumulador_ctrl with an expected-result queue.
module tb_acumulador_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, busy, done, Z, N, P, V;
  logic [7:0] S;

  typedef struct packed {
    logic [7:0] s;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  logic signed [7:0] ops [16];
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;

  acumulador_ctrl #(.NUM_BITS(8), .CNT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done), .S(S), .Z(Z), .N(N), .P(P), .V(V)
  );

  always #5 clk = ~clk;

  // Count done pulses mid-cycle, away from the sampling edge.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Builds the expected result from the operand table, then drives the run.
  task automatic drive_run(input int n, input int gap, input bit poke);
    logic signed [7:0] acc;
    bit ovf;
    int full;
    exp_t e;
    acc = 8'sd0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      full = int'(acc) + int'(ops[i]);
      if (full > 127 || full < -128) ovf = 1'b1;
      acc = full[7:0];
    end
    e.s = acc;
    e.v = ovf;
    exp_q.push_back(e);
    start = 1'b1; len = n[3:0]; in_valid = 1'b0;
    tick;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          if (poke && g == 0) begin start = 1'b1; len = 4'd5; end
          tick;
          start = 1'b0;
        end
      end
      in_valid = 1'b1; in_data = ops[i];
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; len = 4'd0; in_valid = 1'b0; in_data = 8'd0;
    tick; tick;
    compared++;
    if ({in_ready, busy, done, S, Z, N, P, V} !== {3'b000, 8'h00, 4'b1010}) begin
      mismatched++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b S=%h ZNPV=%b%b%b%b want 0 0 0 00 1010",
               in_ready, busy, done, S, Z, N, P, V);
    end
    rst_n = 1'b1;
    tick; tick; tick;
    compared++;
    if ({in_ready, busy, done, S, Z, N, P, V} !== {3'b000, 8'h00, 4'b1010}) begin
      mismatched++;
      $display("FAIL reset_idle_hold: got rdy=%b busy=%b done=%b S=%h ZNPV=%b%b%b%b want 0 0 0 00 1010",
               in_ready, busy, done, S, Z, N, P, V);
    end
  endtask

  task automatic test_basic_sum;
    exp_t e;
    int w;
    ops[0] = 8'sd10; ops[1] = -8'sd3; ops[2] = 8'sd5;
    start = 1'b1; len = 4'd3; in_valid = 1'b0;
    tick;
    start = 1'b0;
    compared++;
    if ({in_ready, busy, done} !== 3'b110) begin
      mismatched++;
      $display("FAIL basic_ready_after_start: got rdy/busy/done=%b%b%b want 110", in_ready, busy, done);
    end
    // Rewind: use drive_run for the actual scored run after this run finishes.
    for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = ops[i]; tick; end
    in_valid = 1'b0;
    tick;
    drive_run(3, 0, 1'b0);
    w = 0;
    while (done !== 1'b1 && w < 5) begin tick; w++; end
    compared++;
    if (w !== 0) begin
      mismatched++;
      $display("FAIL basic_latency: got done %0d cycles late want 0", w);
    end
    e = exp_q.pop_front();
    compared++;
    if ({done, in_ready, busy, S, Z, N, P, V} !== {3'b101, e.s, e.s == 8'd0, e.s[7], ~e.s[0], e.v}) begin
      mismatched++;
      $display("FAIL basic_result: got done=%b rdy=%b busy=%b S=%h ZNPV=%b%b%b%b want 1 0 1 S=%h V=%b",
               done, in_ready, busy, S, Z, N, P, V, e.s, e.v);
    end
    compared++;
    if (S !== 8'd12) begin
      mismatched++;
      $display("FAIL basic_value: got S=%0d want 12", $signed(S));
    end
    tick;
    compared++;
    if ({done, busy, in_ready, S} !== {3'b000, 8'd12}) begin
      mismatched++;
      $display("FAIL basic_back_to_idle: got done=%b busy=%b rdy=%b S=%h want 0 0 0 0c", done, busy, in_ready, S);
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    int w;
    ops[0] = 8'sd100; ops[1] = 8'sd100;
    drive_run(2, 0, 1'b0);
    w = 0;
    while (done !== 1'b1 && w < 5) begin tick; w++; end
    e = exp_q.pop_front();
    compared++;
    if ({done, S, Z, N, P, V} !== {1'b1, e.s, e.s == 8'd0, e.s[7], ~e.s[0], e.v} || S !== 8'hC8 || V !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_wrap: got done=%b S=%h ZNPV=%b%b%b%b want 1 c8 0111", done, S, Z, N, P, V);
    end
    tick;
    ops[0] = 8'sd5; ops[1] = -8'sd5;
    drive_run(2, 0, 1'b0);
    w = 0;
    while (done !== 1'b1 && w < 5) begin tick; w++; end
    e = exp_q.pop_front();
    compared++;
    if ({done, S, Z, N, P, V} !== {1'b1, e.s, e.s == 8'd0, e.s[7], ~e.s[0], e.v} || V !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_cleared: got done=%b S=%h ZNPV=%b%b%b%b want 1 00 1010", done, S, Z, N, P, V);
    end
    tick;
  endtask

  task automatic test_len_zero;
    int d0;
    d0 = done_cnt;
    exp_q.push_back('{s: 8'h00, v: 1'b0});
    start = 1'b1; len = 4'd0; in_valid = 1'b1; in_data = 8'd55;
    tick;
    start = 1'b0;
    begin
      exp_t e;
      e = exp_q.pop_front();
      compared++;
      if ({done, in_ready, busy, S, Z, N, P, V} !== {3'b101, e.s, 4'b1010}) begin
        mismatched++;
        $display("FAIL len0_result: got done=%b rdy=%b busy=%b S=%h ZNPV=%b%b%b%b want 1 0 1 00 1010",
                 done, in_ready, busy, S, Z, N, P, V);
      end
    end
    tick;
    in_valid = 1'b0;
    tick;
    compared++;
    if ({done, in_ready, busy, S} !== {3'b000, 8'h00} || done_cnt - d0 !== 1) begin
      mismatched++;
      $display("FAIL len0_single_pulse: got done=%b rdy=%b busy=%b S=%h pulses=%0d want 0 0 0 00 1",
               done, in_ready, busy, S, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back_gaps;
    exp_t e;
    int w, d0;
    d0 = done_cnt;
    ops[0] = 8'sd7; ops[1] = 8'sd1;
    drive_run(2, 3, 1'b1);
    w = 0;
    while (done !== 1'b1 && w < 5) begin tick; w++; end
    e = exp_q.pop_front();
    compared++;
    if ({done, S, Z, N, P, V} !== {1'b1, e.s, e.s == 8'd0, e.s[7], ~e.s[0], e.v} || S !== 8'd8 || w !== 0) begin
      mismatched++;
      $display("FAIL gap_result: got done=%b S=%h ZNPV=%b%b%b%b late=%0d want 1 08 0010 0",
               done, S, Z, N, P, V, w);
    end
    for (int i = 0; i < 8; i++) tick;
    compared++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL gap_ignored_start: got pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    int w, d0;
    d0 = done_cnt;
    start = 1'b1; len = 4'd4;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd20; tick;
    in_data = 8'd30; tick;
    in_valid = 1'b0; rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    compared++;
    if ({in_ready, busy, done, S, V} !== {3'b000, 8'h00, 1'b0}) begin
      mismatched++;
      $display("FAIL midrst_state: got rdy=%b busy=%b done=%b S=%h V=%b want 0 0 0 00 0", in_ready, busy, done, S, V);
    end
    for (int i = 0; i < 5; i++) tick;
    compared++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_no_done: got pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
    ops[0] = -8'sd1;
    drive_run(1, 0, 1'b0);
    w = 0;
    while (done !== 1'b1 && w < 5) begin tick; w++; end
    e = exp_q.pop_front();
    compared++;
    if ({done, S, Z, N, P, V} !== {1'b1, e.s, e.s == 8'd0, e.s[7], ~e.s[0], e.v} || {S, N, P} !== {8'hFF, 2'b10}) begin
      mismatched++;
      $display("FAIL midrst_new_run: got done=%b S=%h ZNPV=%b%b%b%b want 1 ff 0100", done, S, Z, N, P, V);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic_sum;
    test_overflow;
    test_len_zero;
    test_back_to_back_gaps;
    test_reset_mid_run;
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/acumulador_ctrl.md
# acumulador_ctrl

Sequencer that drives an internal NUM_BITS signed adder to sum a stream of `len` operands into a registered accumulator. Operands arrive over a valid/ready handshake. Zero, negative, even and sticky-overflow flags are reported on the final result. It sits between an operand source (switches or a test FSM) and the result display logic, and owns the adder exclusively while busy.

## Interface
- NUM_BITS, 8, operand/accumulator width (signed, two's complement)
- CNT_BITS, 4, width of the operand-count field; max run length 2^CNT_BITS-1

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- len  in  CNT_BITS  number of operands in the run, sampled with start; 0 allowed
- in_valid  in  1  operand present on in_data
- in_data  in  NUM_BITS  signed operand
- in_ready  out  1  block accepts an operand this cycle
- busy  out  1  run in progress (ACC or DONE)
- done  out  1  one-cycle pulse, result valid
- S  out  NUM_BITS  signed result, registered, holds until next done
- Z  out  1  S == 0
- N  out  1  S[NUM_BITS-1]
- P  out  1  S[0] == 0 (even)
- V  out  1  sticky signed overflow of the last completed run

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1: acc<=0, rem<=len, ovf<=0.
  - Next state is DONE if len==0, else ACC.
- ACC:
  - in_ready=1, busy=1.
  - Accept = in_valid & in_ready.
  - On accept: acc <= acc + in_data, truncated mod 2^NUM_BITS (wraps); ovf <= ovf | (sign(acc)==sign(in_data) & sign(sum)!=sign(acc)); rem <= rem-1.
  - Accept with rem==1 → DONE.
  - in_valid=0: hold, no state change, no timeout.
- DONE:
  - in_ready=0, busy=1, done=1.
  - S<=acc and V<=ovf, registered on entry to DONE and visible in the DONE cycle.
  - Next state IDLE unconditionally.
- Z/N/P are combinational from the S register only. They never reflect partial sums.
- start asserted in ACC or DONE is ignored: not queued, len not resampled.
- Only one operand is accepted per cycle. in_data is ignored when in_ready=0.
- Reset (rst_n=0 at a rising edge), any state, including mid-run: state=IDLE, acc=0, rem=0, ovf=0, S=0, V=0. Partial sum is discarded.
- Reset values of outputs: in_ready=0, busy=0, done=0, S=0, Z=1, N=0, P=1, V=0.

## Timing
- start sampled at edge t → in_ready=1 and busy=1 from cycle t+1.
- Operand accepted at each edge where in_valid=in_ready=1.
- Final operand accepted at edge k → done=1, S/flags/V updated during cycle k+1. in_ready=0 from k+1.
- IDLE at cycle k+2. Earliest next start is sampled at edge k+2.
- len=0: start at t → done pulse in cycle t+1, S=0, Z=1, V=0.
- Minimum run latency with in_valid held high: len+1 cycles from start edge to done.
- S/V/Z/N/P are stable outside the DONE-entry edge and unchanged during ACC.

## Test plan
- Reset check: hold rst_n=0 2 cycles, then release → in_ready=0, busy=0, done=0, S=0, Z=1, N=0, P=1, V=0; no change without start.
- Basic sum: start, len=3; operands 10, -3, 5 back-to-back → done at 4th cycle after start, S=12, Z=0, N=0, P=1, V=0.
- Overflow and wrap: len=2; operands 100, 100 → S=-56 (8'hC8), N=1, P=1, V=1. Then len=2 with 5, -5 → S=0, Z=1, V=0 (V cleared per run).
- Handshake gaps and ignored start: len=2; in_valid low 3 cycles between operands 7 and 1; pulse start during ACC → S=8; one done pulse only; len not resampled.
- len=0: start with len=0 → done exactly one cycle later, S=0, Z=1, P=1; no operand consumed while in_valid=1.
- Reset mid-run: len=4; after 2 operands (20, 30) assert rst_n=0 one edge → IDLE, S=0, V=0, no done. A new run of len=1, operand -1 → S=-1, N=1, P=0.
